cronometro_bcd: RTL and testbench

Parametrised BCD elapsed-time counter for the pill dispenser: counts seconds, minutes, hours (00–23) and a configurable number of day digits from a fast system clock. It extends the fixed 10 kHz day/hour/minute stopwatch with a configurable prescaler, a seconds field and run/pause control. It also adds synchronous preset load with range checking, and single-cycle tick pulses that the dose scheduler uses as its time base.

---
 rtl/cronometro_bcd.sv | 165 ++++++++++++++++
 tb/tb_cronometro_bcd.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cronometro_bcd.sv
// BCD elapsed-time counter {days, hh, mm, ss} with prescaler, run/pause and range-checked preset load.
// Optional daily hh:mm alarm (alarma_hm / alarma) is compiled in when CRONO_ALARMA_EN is defined.
module cronometro_bcd #(
  parameter  int TICKS_PER_SEC = 10000,
  parameter  int DAY_DIGITS    = 2,
  localparam int TW            = 4*DAY_DIGITS + 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  input  logic [TW-1:0] preset,
  output logic [TW-1:0] tiempo,
  output logic          tick_seg,
  output logic          tick_min,
  output logic          dia_wrap,
  output logic          preset_err
`ifdef CRONO_ALARMA_EN
  ,
  input  logic [15:0]   alarma_hm,
  output logic          alarma
`endif
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int ND = TW / 4;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] time_q, time_d;
  logic          tick_seg_q, tick_seg_d;
  logic          tick_min_q, tick_min_d;
  logic          dia_wrap_q, dia_wrap_d;
  logic          preset_err_q, preset_err_d;

  logic [3:0] seg1, seg2, min1, min2, hora1, hora2;
  logic [3:0] seg1_n, seg2_n, min1_n, min2_n, hora1_n, hora2_n;
  logic       c_s1, c_s2, c_m1, c_m2, c_h;
  logic [DAY_DIGITS:0]     day_c;
  logic [4*DAY_DIGITS-1:0] days_n;
  logic [TW-1:0]           time_adv;
  logic [ND-1:0]           dig_ok;
  logic                    preset_ok;

  assign seg1  = time_q[3:0];
  assign seg2  = time_q[7:4];
  assign min1  = time_q[11:8];
  assign min2  = time_q[15:12];
  assign hora1 = time_q[19:16];
  assign hora2 = time_q[23:20];

  // Whole one-second advance computed combinationally so every rollover lands in one edge.
  always_comb begin
    c_s1 = (seg1 == 4'd9);
    c_s2 = c_s1 && (seg2 == 4'd5);
    c_m1 = c_s2 && (min1 == 4'd9);
    c_m2 = c_m1 && (min2 == 4'd5);
    c_h  = c_m2 && (hora2 == 4'd2) && (hora1 == 4'd3);

    seg1_n  = c_s1 ? 4'd0 : seg1 + 4'd1;
    seg2_n  = c_s1 ? (c_s2 ? 4'd0 : seg2 + 4'd1) : seg2;
    min1_n  = c_s2 ? (c_m1 ? 4'd0 : min1 + 4'd1) : min1;
    min2_n  = c_m1 ? (c_m2 ? 4'd0 : min2 + 4'd1) : min2;
    hora1_n = c_m2 ? ((c_h || hora1 == 4'd9) ? 4'd0 : hora1 + 4'd1) : hora1;
    hora2_n = c_m2 ? (c_h ? 4'd0 : ((hora1 == 4'd9) ? hora2 + 4'd1 : hora2)) : hora2;

    day_c    = '0;
    day_c[0] = c_h;
    days_n   = time_q[TW-1:24];
    for (int i = 0; i < DAY_DIGITS; i++) begin
      if (day_c[i]) begin
        days_n[4*i +: 4] = (time_q[24+4*i +: 4] == 4'd9) ? 4'd0 : time_q[24+4*i +: 4] + 4'd1;
      end
      day_c[i+1] = day_c[i] && (time_q[24+4*i +: 4] == 4'd9);
    end

    time_adv = {days_n, hora2_n, hora1_n, min2_n, min1_n, seg2_n, seg1_n};
  end

  generate
    for (genvar gi = 0; gi < ND; gi++) begin : g_dig_ok
      assign dig_ok[gi] = (preset[4*gi +: 4] <= 4'd9);
    end
  endgenerate

  assign preset_ok = (&dig_ok) &&
                     (preset[7:4] <= 4'd5) &&
                     (preset[15:12] <= 4'd5) &&
                     ((preset[23:20] < 4'd2) ||
                      ((preset[23:20] == 4'd2) && (preset[19:16] <= 4'd3)));

`ifdef CRONO_ALARMA_EN
  logic alarma_q, alarma_d;
  logic alarm_match;
  // Seconds reach 00 only through the seg2 carry, so c_s2 marks entry into hh:mm:00.
  assign alarm_match = c_s2 && (time_adv[23:8] == alarma_hm);
`endif

  always_comb begin
    presc_d      = presc_q;
    time_d       = time_q;
    tick_seg_d   = 1'b0;
    tick_min_d   = 1'b0;
    dia_wrap_d   = 1'b0;
    preset_err_d = 1'b0;
`ifdef CRONO_ALARMA_EN
    alarma_d     = 1'b0;
`endif
    if (load) begin
      if (preset_ok) begin
        time_d  = preset;
        presc_d = '0;
      end else begin
        preset_err_d = 1'b1;
      end
    end else if (en) begin
      if (presc_q == PRESC_LAST) begin
        presc_d    = '0;
        time_d     = time_adv;
        tick_seg_d = 1'b1;
        tick_min_d = c_s2;
        dia_wrap_d = day_c[DAY_DIGITS];
`ifdef CRONO_ALARMA_EN
        alarma_d   = alarm_match;
`endif
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      time_q       <= '0;
      tick_seg_q   <= 1'b0;
      tick_min_q   <= 1'b0;
      dia_wrap_q   <= 1'b0;
      preset_err_q <= 1'b0;
`ifdef CRONO_ALARMA_EN
      alarma_q     <= 1'b0;
`endif
    end else begin
      presc_q      <= presc_d;
      time_q       <= time_d;
      tick_seg_q   <= tick_seg_d;
      tick_min_q   <= tick_min_d;
      dia_wrap_q   <= dia_wrap_d;
      preset_err_q <= preset_err_d;
`ifdef CRONO_ALARMA_EN
      alarma_q     <= alarma_d;
`endif
    end
  end

  assign tiempo     = time_q;
  assign tick_seg   = tick_seg_q;
  assign tick_min   = tick_min_q;
  assign dia_wrap   = dia_wrap_q;
  assign preset_err = preset_err_q;
`ifdef CRONO_ALARMA_EN
  assign alarma     = alarma_q;
`endif

endmodule

// File: tb/tb_cronometro_bcd.sv
// Randomised bench for cronometro_bcd against a seconds-of-day reference model, plus directed scenarios.
module tb_cronometro_bcd;

  localparam int TPS    = 4;
  localparam int DD     = 2;
  localparam int TW     = 4*DD + 24;
  localparam int DAYMAX = 10**DD;

  logic          clk = 1'b0;
  logic          rst, en, load;
  logic [TW-1:0] preset;
  logic [TW-1:0] tiempo;
  logic          tick_seg, tick_min, dia_wrap, preset_err;
`ifdef CRONO_ALARMA_EN
  logic [15:0]   alarma_hm;
  logic          alarma;
`endif

  always #5 clk = ~clk;

  cronometro_bcd #(.TICKS_PER_SEC(TPS), .DAY_DIGITS(DD)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .preset     (preset),
    .tiempo     (tiempo),
    .tick_seg   (tick_seg),
    .tick_min   (tick_min),
    .dia_wrap   (dia_wrap),
    .preset_err (preset_err)
`ifdef CRONO_ALARMA_EN
    ,
    .alarma_hm  (alarma_hm),
    .alarma     (alarma)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: elapsed days plus seconds-of-day, and a plain prescaler count.
  int m_days, m_sod, m_pre;
  bit m_ts, m_tm, m_dw, m_pe, m_al;
  bit m_valid = 1'b0;

  function automatic logic [TW-1:0] enc(input int days, input int sod);
    logic [TW-1:0] r;
    int h, m, s, d;
    h = sod / 3600;
    m = (sod / 60) % 60;
    s = sod % 60;
    r = '0;
    r[3:0]   = 4'(s % 10);
    r[7:4]   = 4'(s / 10);
    r[11:8]  = 4'(m % 10);
    r[15:12] = 4'(m / 10);
    r[19:16] = 4'(h % 10);
    r[23:20] = 4'(h / 10);
    d = days;
    for (int i = 0; i < DD; i++) begin
      r[24+4*i +: 4] = 4'(d % 10);
      d = d / 10;
    end
    return r;
  endfunction

  task automatic decode(input logic [TW-1:0] p, output bit ok, output int days, output int sod);
    int h, m, s, mul;
    ok = 1'b1;
    for (int i = 0; i < TW/4; i++) if (p[4*i +: 4] > 4'd9) ok = 1'b0;
    s = int'(p[7:4]) * 10 + int'(p[3:0]);
    m = int'(p[15:12]) * 10 + int'(p[11:8]);
    h = int'(p[23:20]) * 10 + int'(p[19:16]);
    if (s > 59 || m > 59 || h > 23) ok = 1'b0;
    sod  = h*3600 + m*60 + s;
    days = 0;
    mul  = 1;
    for (int i = 0; i < DD; i++) begin
      days = days + int'(p[24+4*i +: 4]) * mul;
      mul  = mul * 10;
    end
  endtask

  task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit ok;
    int d, s;
    logic [TW-1:0] v;
    m_ts = 0; m_tm = 0; m_dw = 0; m_pe = 0; m_al = 0;
    if (rst) begin
      m_days = 0; m_sod = 0; m_pre = 0; m_valid = 1'b1;
    end else if (load) begin
      decode(preset, ok, d, s);
      if (ok) begin
        m_days = d; m_sod = s; m_pre = 0;
      end else begin
        m_pe = 1;
      end
    end else if (en) begin
      if (m_pre == TPS-1) begin
        m_pre = 0;
        m_sod++;
        m_ts = 1;
        if (m_sod % 60 == 0) m_tm = 1;
        if (m_sod == 86400) begin
          m_sod = 0;
          m_days++;
          if (m_days == DAYMAX) begin
            m_days = 0;
            m_dw = 1;
          end
        end
`ifdef CRONO_ALARMA_EN
        v = enc(0, m_sod);
        if (m_sod % 60 == 0 && v[23:8] == alarma_hm) m_al = 1;
`endif
      end else begin
        m_pre++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("tiempo", tiempo, enc(m_days, m_sod));
      check("tick_seg", TW'(tick_seg), TW'(m_ts));
      check("tick_min", TW'(tick_min), TW'(m_tm));
      check("dia_wrap", TW'(dia_wrap), TW'(m_dw));
      check("preset_err", TW'(preset_err), TW'(m_pe));
`ifdef CRONO_ALARMA_EN
      check("alarma", TW'(alarma), TW'(m_al));
`endif
    end
  end

  task automatic lit(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    #1;
    check(name, act, exp);
  endtask

  task automatic do_load(input logic [TW-1:0] p);
    load = 1'b1; preset = p;
    step();
    load = 1'b0;
  endtask

  initial begin
    logic [TW-1:0] tmp;
    int mode;
    rst = 1'b1; en = 1'b1; load = 1'b0; preset = '0;
`ifdef CRONO_ALARMA_EN
    alarma_hm = 16'h0730;
`endif
    step(); step();
    lit("reset_tiempo", tiempo, 32'h0);
    lit("reset_tick", TW'(tick_seg), 32'h0);
    rst = 1'b0;

    // Prescale: first tick at edge TPS after reset release, then every TPS edges
    step(); step(); step();
    lit("pre_no_tick", TW'(tick_seg), 32'h0);
    step();
    lit("first_tick", TW'(tick_seg), 32'h1);
    lit("first_sec", tiempo, 32'h00000001);
    repeat (4) step();
    lit("second_sec", tiempo, 32'h00000002);

    // Full rollover without and with day wrap
    do_load(32'h09235959);
    repeat (4) step();
    lit("roll_tiempo", tiempo, 32'h10000000);
    lit("roll_tick_min", TW'(tick_min), 32'h1);
    lit("roll_no_wrap", TW'(dia_wrap), 32'h0);
    do_load(32'h99235959);
    repeat (4) step();
    lit("wrap_tiempo", tiempo, 32'h00000000);
    lit("wrap_pulse", TW'(dia_wrap), 32'h1);

    // Illegal presets are rejected
    do_load(32'h00240000);
    lit("bad_hour_err", TW'(preset_err), 32'h1);
    lit("bad_hour_hold", tiempo, 32'h00000000);
    do_load(32'h00126000);
    lit("bad_min_err", TW'(preset_err), 32'h1);
    lit("bad_min_hold", tiempo, 32'h00000000);

    // Pause at prescaler count 2
    do_load(32'h00010203);
    step(); step();
    en = 1'b0;
    repeat (10) step();
    lit("pause_hold", tiempo, 32'h00010203);
    en = 1'b1;
    step();
    lit("resume_no_tick", TW'(tick_seg), 32'h0);
    step();
    lit("resume_tick", TW'(tick_seg), 32'h1);
    lit("resume_sec", tiempo, 32'h00010204);

    // Load on the terminal-count cycle wins
    do_load(32'h00010000);
    repeat (3) step();
    do_load(32'h00050000);
    lit("ld_tc_tiempo", tiempo, 32'h00050000);
    lit("ld_tc_no_tick", TW'(tick_seg), 32'h0);
    repeat (3) step();
    step();
    lit("ld_tc_next_tick", TW'(tick_seg), 32'h1);

`ifdef CRONO_ALARMA_EN
    alarma_hm = 16'h0730;
    do_load(32'h00072958);
    repeat (8) step();
    lit("alarm_fire", TW'(alarma), 32'h1);
    lit("alarm_time", tiempo, 32'h00073000);
    repeat (4) step();
    lit("alarm_once", TW'(alarma), 32'h0);
    do_load(32'h00073000);
    lit("alarm_no_load", TW'(alarma), 32'h0);
`endif

    // Randomised traffic
    for (int it = 0; it < 3000; it++) begin
      rst  = ($urandom_range(0, 299) == 0);
      en   = ($urandom_range(0, 7) != 0);
      load = ($urandom_range(0, 24) == 0);
      mode = $urandom_range(0, 2);
      if (mode == 0)      preset = enc($urandom_range(0, DAYMAX-1), $urandom_range(0, 86399));
      else if (mode == 1) preset = enc(($urandom_range(0, 1) != 0) ? DAYMAX-1 : $urandom_range(0, DAYMAX-1),
                                       86400 - $urandom_range(1, 6));
      else                preset = TW'($urandom());
`ifdef CRONO_ALARMA_EN
      if ($urandom_range(0, 19) == 0) begin
        tmp = enc(0, (m_sod + 60) % 86400);
        alarma_hm = tmp[23:8];
      end
`endif
      step();
    end
    rst = 1'b0; load = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
